// File: rtl/lch_gsw2cl_gearbox_pkg.sv
// Shared widths and FSM encoding for the switch-to-cluster return gearbox.
package lch_gsw2cl_gearbox_pkg;

  localparam int LCH_GSWDATWID = 3;
  localparam int COM_CLDATWID  = 2;

  typedef enum logic {
    LCH_CL_FILL  = 1'b0,
    LCH_CL_DRAIN = 1'b1
  } lch_cl_state_e;

endpackage

// File: rtl/lch_gsw2cl_gearbox.sv
// Repacks switch words LSB-first into cluster beats through a bit accumulator.
// Frames end with a last flag; a short tail beat is zero-padded.
module lch_gsw2cl_gearbox
  import lch_gsw2cl_gearbox_pkg::*;
#(
  parameter int IN_W  = LCH_GSWDATWID,
  parameter int OUT_W = COM_CLDATWID,
  parameter int ACC_W = 2 * IN_W,
  parameter int CNT_W = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             sw_valid,
  output logic             sw_ready,
  input  logic [IN_W-1:0]  sw_data,
  input  logic             sw_last,
  output logic             cl_valid,
  input  logic             cl_ready,
  output logic [OUT_W-1:0] cl_data,
  output logic             cl_last,
  output logic             busy
);

  localparam logic [CNT_W:0] IN_C  = (CNT_W + 1)'(IN_W);
  localparam logic [CNT_W:0] OUT_C = (CNT_W + 1)'(OUT_W);
  localparam logic [CNT_W:0] ACC_C = (CNT_W + 1)'(ACC_W);

  if (ACC_W < IN_W + OUT_W) begin : g_acc_too_small
    $error("lch_gsw2cl_gearbox: ACC_W must be at least IN_W + OUT_W");
  end

  logic [ACC_W-1:0] acc, acc_pop, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_e, cnt_pop, cnt_nxt;
  lch_cl_state_e    state, state_nxt;
  logic             push, pop;

  assign cnt_e = {1'b0, cnt};
  assign pop   = cl_valid && cl_ready;
  assign push  = sw_valid && sw_ready;

  // Pop first, then merge the incoming word above the surviving bits.
  always_comb begin
    acc_pop   = acc;
    cnt_pop   = cnt_e;
    state_nxt = state;
    if (pop) begin
      acc_pop = acc >> OUT_W;
      cnt_pop = (cnt_e >= OUT_C) ? (cnt_e - OUT_C) : '0;
    end
    acc_nxt = acc_pop;
    cnt_nxt = cnt_pop;
    if (push) begin
      acc_nxt = acc_pop | (ACC_W'(sw_data) << cnt_pop);
      cnt_nxt = cnt_pop + IN_C;
    end
    if (push && sw_last) begin
      state_nxt = LCH_CL_DRAIN;
    end else if (pop && cl_last) begin
      state_nxt = LCH_CL_FILL;
    end
  end

  // Outputs are decoded from the next register values so they leave the block registered.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      acc      <= '0;
      cnt      <= '0;
      state    <= LCH_CL_FILL;
      sw_ready <= 1'b1;
      cl_valid <= 1'b0;
      cl_data  <= '0;
      cl_last  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      acc      <= acc_nxt;
      cnt      <= cnt_nxt[CNT_W-1:0];
      state    <= state_nxt;
      sw_ready <= (state_nxt == LCH_CL_FILL) && ((cnt_nxt + IN_C) <= ACC_C);
      cl_valid <= (cnt_nxt >= OUT_C) || ((state_nxt == LCH_CL_DRAIN) && (cnt_nxt != '0));
      cl_data  <= acc_nxt[OUT_W-1:0];
      cl_last  <= (state_nxt == LCH_CL_DRAIN) && (cnt_nxt <= OUT_C) && (cnt_nxt != '0);
      busy     <= (cnt_nxt != '0) || (state_nxt == LCH_CL_DRAIN);
    end
  end

  // A stalled source must keep its word steady until it is taken.
  a_sw_data_stable: assert property (@(posedge clk) disable iff (!reset_l)
    (sw_valid && !sw_ready) |=> (!sw_valid || $stable(sw_data)));

endmodule
